detect_sequencer: RTL

Sequencer for the LTSSM Detect phase (Detect.Quiet / Detect.Active) across all lanes of the link. It drives the PIPE control signals TxDetectRx_Loopback, PowerDown and TxElecIdle. It also collects the per-lane receiver-detect results reported through PhyStatus/RxStatus and applies the two-pass partial-detect rule. It sits between the LTSSM top level (start/abort/done) and the PHY's PIPE interface.

---
 rtl/detect_sequencer_if.sv | 28 ++
 rtl/detect_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/detect_sequencer_if.sv
// PIPE-side signal bundle between the detect sequencer and the PHY.
// The sequencer (master) owns the transmit controls; the PHY (slave) reports
// receiver-detect completion and per-lane status.
interface detect_sequencer_if #(
   parameter int NUM_LANES = 4
);
   logic                   TxDetectRx_Loopback;
   logic [3:0]             PowerDown;
   logic                   TxElecIdle;
   logic                   PhyStatus;
   logic [3*NUM_LANES-1:0] RxStatus;

   modport master (
      output TxDetectRx_Loopback,
      output PowerDown,
      output TxElecIdle,
      input  PhyStatus,
      input  RxStatus
   );

   modport slave (
      input  TxDetectRx_Loopback,
      input  PowerDown,
      input  TxElecIdle,
      output PhyStatus,
      output RxStatus
   );
endinterface

// File: rtl/detect_sequencer.sv
// LTSSM Detect sequencer: alternates Detect.Quiet and Detect.Active across all
// lanes, gathers per-lane receiver-detect results from the PHY and applies the
// two-pass partial-detect rule before reporting the detected-lane mask.
module detect_sequencer #(
   parameter int NUM_LANES    = 4,
   parameter int QUIET_CYCLES = 1000,
   parameter int PHY_TIMEOUT  = 256
) (
   input  logic                  pclk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  elec_idle_req,
   detect_sequencer_if.master    pipe,
   output logic                  busy,
   output logic                  done,
   output logic [NUM_LANES-1:0]  lanes_detected,
   output logic                  phy_timeout_err
);

   localparam int CNT_MAX = (QUIET_CYCLES > PHY_TIMEOUT) ? QUIET_CYCLES : PHY_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] QUIET_LAST   = CNT_W'(QUIET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PHY_TIMEOUT - 1);
   localparam logic [3:0]       PD_P1        = 4'b0010;
   localparam logic [2:0]       RX_PRESENT   = 3'b011;

   typedef enum logic [2:0] {
      IDLE,
      QUIET,
      ACTIVE,
      EVAL,
      DONE
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic                 pass;
   logic                 tx_detect;
   logic                 tx_elec_idle;
   logic [3:0]           power_down;
   logic [NUM_LANES-1:0] cur_mask;
   logic [NUM_LANES-1:0] first_mask;
   logic [NUM_LANES-1:0] rx_present;

   assign pipe.TxDetectRx_Loopback = tx_detect;
   assign pipe.TxElecIdle          = tx_elec_idle;
   assign pipe.PowerDown           = power_down;

   // Per-lane "receiver present" decode of the PHY status bus.
   always_comb begin
      rx_present = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         rx_present[i] = (pipe.RxStatus[3*i +: 3] == RX_PRESENT);
      end
   end

   // Detect-result datapath: current pass capture and the first partial pass
   // kept for comparison; always written before being consumed, so no reset.
   always_ff @(posedge pclk) begin
      if (state == ACTIVE) begin
         cur_mask <= pipe.PhyStatus ? rx_present : '0;
      end
      if (state == EVAL && cur_mask != '0 && !(&cur_mask) && !pass) begin
         first_mask <= cur_mask;
      end
   end

   // Control FSM with registered PIPE and LTSSM outputs; abort has priority
   // over every decision made outside IDLE.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         cnt             <= '0;
         pass            <= 1'b0;
         tx_detect       <= 1'b0;
         tx_elec_idle    <= 1'b1;
         power_down      <= PD_P1;
         busy            <= 1'b0;
         done            <= 1'b0;
         lanes_detected  <= '0;
         phy_timeout_err <= 1'b0;
      end else if (abort && state != IDLE) begin
         state        <= IDLE;
         cnt          <= '0;
         pass         <= 1'b0;
         tx_detect    <= 1'b0;
         tx_elec_idle <= elec_idle_req;
         power_down   <= PD_P1;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         power_down <= PD_P1;
         case (state)
            IDLE: begin
               tx_elec_idle <= elec_idle_req;
               if (start) begin
                  state           <= QUIET;
                  cnt             <= '0;
                  pass            <= 1'b0;
                  busy            <= 1'b1;
                  tx_elec_idle    <= 1'b1;
                  lanes_detected  <= '0;
                  phy_timeout_err <= 1'b0;
               end
            end
            QUIET: begin
               tx_elec_idle <= 1'b1;
               if (cnt == QUIET_LAST) begin
                  state     <= ACTIVE;
                  cnt       <= '0;
                  tx_detect <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ACTIVE: begin
               if (pipe.PhyStatus) begin
                  state     <= EVAL;
                  cnt       <= '0;
                  tx_detect <= 1'b0;
               end else if (cnt == TIMEOUT_LAST) begin
                  state           <= EVAL;
                  cnt             <= '0;
                  tx_detect       <= 1'b0;
                  phy_timeout_err <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            EVAL: begin
               cnt <= '0;
               if (cur_mask == '0) begin
                  state <= QUIET;
                  pass  <= 1'b0;
               end else if (&cur_mask) begin
                  state          <= DONE;
                  done           <= 1'b1;
                  lanes_detected <= cur_mask;
                  pass           <= 1'b0;
               end else if (!pass) begin
                  state <= QUIET;
                  pass  <= 1'b1;
               end else if (cur_mask == first_mask) begin
                  state          <= DONE;
                  done           <= 1'b1;
                  lanes_detected <= cur_mask;
                  pass           <= 1'b0;
               end else begin
                  state <= QUIET;
                  pass  <= 1'b0;
               end
            end
            DONE: begin
               state        <= IDLE;
               done         <= 1'b0;
               busy         <= 1'b0;
               tx_elec_idle <= elec_idle_req;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               tx_detect <= 1'b0;
            end
         endcase
      end
   end

endmodule
